// File: rtl/adc_spi_master_pkg.sv
// Shared types and frame layout for the ADC sample SPI master.
package adc_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  localparam int unsigned FRAME_BITS = 16;

  // Field positions inside byte1 of the frame.
  localparam int unsigned CHAN_MSB   = 7;
  localparam int unsigned CHAN_LSB   = 4;
  localparam int unsigned SMP_HI_MSB = 1;

  // Frame as transmitted: byte0 (sample low bits) in [15:8], byte1 in [7:0].
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [9:0] sample,
                                                        input logic [3:0] channel);
    logic [7:0] byte1;
    byte1                    = '0;
    byte1[CHAN_MSB:CHAN_LSB] = channel;
    byte1[SMP_HI_MSB:0]      = sample[9:8];
    return {sample[7:0], byte1};
  endfunction

endpackage

// File: rtl/adc_spi_master_if.sv
// Sample valid/ready handshake between the sample source and the SPI master.
interface adc_spi_master_if;
  import adc_spi_pkg::*;

  logic [9:0] in_sample;
  logic [3:0] in_channel;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output in_sample,
    output in_channel,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_sample,
    input  in_channel,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/adc_spi_master_sck_timer.sv
// Half-period timer for sck: strobes at the end of each CLK_DIV-cycle half.
// rise marks the end of a low half, fall marks the end of a high half.
module spi_sck_timer #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic rise,
  output logic fall,
  output logic level
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          phase;
  logic          half_end;

  assign half_end = en && (cnt == LAST);
  assign rise     = half_end && !phase;
  assign fall     = half_end && phase;
  assign level    = phase;

  // Count cycles within a half period and toggle the phase at its end.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (half_end) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/adc_spi_master.sv
// SPI master (mode 0, MSB first) sending two-byte ADC sample frames.
// Optional miso capture into rx_data: define ADC_SPI_RX_CAPTURE_EN.
module adc_spi_master
  import adc_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned SS_GAP  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  adc_spi_master_if.slave         smp,
  output logic                    spi_ss,
  output logic                    spi_sck,
  output logic                    spi_mosi,
  input  logic                    spi_miso,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             rx_data
);

  localparam int unsigned BW = $clog2(FRAME_BITS);
  localparam int unsigned GW = (SS_GAP > 1) ? $clog2(SS_GAP) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(SS_GAP - 1);

  state_t                state, state_nx;
  logic [FRAME_BITS-1:0] tx_q;
  logic [BW-1:0]         bit_cnt;
  logic [GW-1:0]         gap_cnt;
  logic                  accept;
  logic                  frame_active;
  logic                  last_bit;
  logic                  gap_last;
  logic                  rise, fall, sck_level;

  assign smp.in_ready = (state == IDLE) && !rst;
  assign accept       = (state == IDLE) && smp.in_valid && !rst;
  assign frame_active = (state == SETUP) || (state == SHIFT) || (state == HOLD);
  assign last_bit     = (bit_cnt == LAST_BIT);
  assign gap_last     = (gap_cnt == GAP_LAST);

  // SETUP acts as the low half before the first bit and HOLD as the low half
  // after the last one, so one free-running timer paces the whole ss-low window.
  spi_sck_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .en    (frame_active),
    .rise  (rise),
    .fall  (fall),
    .level (sck_level)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)            state_nx = SETUP;
      SETUP:   if (rise)              state_nx = SHIFT;
      SHIFT:   if (fall && last_bit)  state_nx = HOLD;
      HOLD:    if (rise)              state_nx = GAP;
      GAP:     if (gap_last)          state_nx = IDLE;
      default:                        state_nx = IDLE;
    endcase
  end

  // Frame latch, bit shifting on sck falls, and ss gap counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q    <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      if (accept) begin
        tx_q    <= build_frame(smp.in_sample, smp.in_channel);
        bit_cnt <= '0;
      end else if ((state == SHIFT) && fall && !last_bit) begin
        tx_q    <= {tx_q[FRAME_BITS-2:0], 1'b0};
        bit_cnt <= bit_cnt + BW'(1);
      end
      if ((state == GAP) && !gap_last) gap_cnt <= gap_cnt + GW'(1);
      else                             gap_cnt <= '0;
    end
  end

  assign spi_ss   = !frame_active;
  assign spi_sck  = sck_level && (state == SHIFT);
  assign spi_mosi = frame_active && tx_q[FRAME_BITS-1];
  assign busy     = (state != IDLE);
  assign done     = (state == GAP) && (gap_cnt == '0);

`ifdef ADC_SPI_RX_CAPTURE_EN
  logic [FRAME_BITS-1:0] rx_sh;
  logic [15:0]           rx_q;

  // Shift miso in on each sck rise; publish byte-swapped at the end of HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sh <= '0;
      rx_q  <= '0;
    end else begin
      if (((state == SETUP) || (state == SHIFT)) && rise)
        rx_sh <= {rx_sh[FRAME_BITS-2:0], spi_miso};
      if ((state == HOLD) && rise)
        rx_q <= {rx_sh[7:0], rx_sh[15:8]};
    end
  end

  assign rx_data = rx_q;
`else
  logic miso_unused;
  assign miso_unused = spi_miso;
  assign rx_data     = '0;
`endif

endmodule

// File: tb/tb_adc_spi_master.sv
// Directed bench for adc_spi_master with CLK_DIV=2, SS_GAP=4.
module tb_adc_spi_master;
  import adc_spi_pkg::*;

`ifdef ADC_SPI_RX_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        spi_ss, spi_sck, spi_mosi, spi_miso;
  logic        busy, done;
  logic [15:0] rx_data;

  adc_spi_master_if sif ();

  adc_spi_master #(
    .CLK_DIV (2),
    .SS_GAP  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .smp      (sif.slave),
    .spi_ss   (spi_ss),
    .spi_sck  (spi_sck),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .busy     (busy),
    .done     (done),
    .rx_data  (rx_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Observer and responder state, written only by the monitor.
  int          rises    = 0;
  int          done_cnt = 0;
  int          low_run  = 0;
  int          high_run = 0;
  int          last_low = 0;
  int          last_high = 0;
  logic [31:0] mosi_sh  = '0;
  logic        prev_ss  = 1'b1;
  logic        prev_sck = 1'b0;
  logic [15:0] slv_sh   = '0;
  logic [15:0] slv_din  = 16'hFFFF;

  initial spi_miso = 1'b0;

  // Mode-0 slave model and line monitor, sampled on the falling clk edge.
  always @(negedge clk) begin
    if (!spi_ss) begin
      if (prev_ss) begin
        last_high = high_run;
        high_run  = 0;
        slv_sh    = slv_din;
        spi_miso  = slv_sh[15];
      end
      low_run++;
    end else begin
      if (!prev_ss) last_low = low_run;
      low_run = 0;
      high_run++;
    end
    if (spi_sck && !prev_sck) begin
      rises++;
      mosi_sh = {mosi_sh[30:0], spi_mosi};
    end
    if (!spi_sck && prev_sck && !spi_ss) begin
      slv_sh   = {slv_sh[14:0], 1'b0};
      spi_miso = slv_sh[15];
    end
    if (done === 1'b1) done_cnt++;
    prev_ss  = spi_ss;
    prev_sck = spi_sck;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output bit ok);
    int start;
    ok    = 1'b0;
    start = done_cnt;
    for (int i = 0; i < 300 && !ok; i++) begin
      cyc(1);
      if (done_cnt != start) ok = 1'b1;
    end
  endtask

  function automatic logic [21:0] outs();
    return {spi_ss, spi_sck, spi_mosi, sif.in_ready, busy, done, rx_data};
  endfunction

  localparam logic [21:0] RST_OUTS = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};

  initial begin
    bit ok;
    int base_r;
    int base_d;

    rst            = 1'b1;
    sif.in_valid   = 1'b0;
    sif.in_sample  = '0;
    sif.in_channel = '0;

    // Reset held for three cycles.
    cyc(1);
    chk("reset_c1", outs(), RST_OUTS);
    cyc(1);
    chk("reset_c2", outs(), RST_OUTS);
    cyc(1);
    chk("reset_c3", outs(), RST_OUTS);
    rst = 1'b0;
    cyc(1);
    chk("ready_after_rst", {sif.in_ready, busy, spi_ss}, 3'b101);

    // Single frame 0x2A5 / ch 3.
    slv_din        = 16'hFFFF;
    sif.in_sample  = 10'h2A5;
    sif.in_channel = 4'h3;
    sif.in_valid   = 1'b1;
    base_r = rises;
    base_d = done_cnt;
    cyc(1);
    sif.in_valid = 1'b0;
    chk("setup_lines", {spi_ss, spi_sck, spi_mosi, sif.in_ready, busy}, 5'b00101);
    wait_done(ok);
    chk("f1_done_seen", ok, 1);
    chk("f1_bytes", mosi_sh[15:0], 16'hA532);
    chk("f1_ss_low", last_low, 66);
    chk("f1_rises", rises - base_r, 16);
    chk("f1_ss_at_done", spi_ss, 1'b1);
    chk("f1_rx", rx_data, CAP ? 16'hFFFF : 16'h0000);
    cyc(3);
    chk("f1_gap_end", {busy, sif.in_ready}, 2'b10);
    cyc(1);
    chk("f1_idle", {busy, sif.in_ready}, 2'b01);
    chk("f1_done_once", done_cnt - base_d, 1);

    // Back-to-back frames with in_valid held high.
    sif.in_sample  = 10'h3FF;
    sif.in_channel = 4'hF;
    sif.in_valid   = 1'b1;
    base_r = rises;
    cyc(1);
    sif.in_sample  = 10'h000;
    sif.in_channel = 4'h0;
    wait_done(ok);
    chk("b2b_done1_seen", ok, 1);
    chk("b2b_bytes1", mosi_sh[15:0], 16'hFFF3);
    wait_done(ok);
    sif.in_valid = 1'b0;
    chk("b2b_done2_seen", ok, 1);
    chk("b2b_bytes2", mosi_sh[15:0], 16'h0000);
    chk("b2b_ss_high", last_high, 5);
    chk("b2b_rises", rises - base_r, 32);
    cyc(4);
    chk("b2b_idle", sif.in_ready, 1'b1);

    // Reset in the middle of SHIFT (bit index 9).
    sif.in_sample  = 10'h155;
    sif.in_channel = 4'h5;
    sif.in_valid   = 1'b1;
    cyc(1);
    sif.in_valid = 1'b0;
    base_r = rises;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      cyc(1);
      if (rises - base_r == 10) ok = 1'b1;
    end
    chk("mid_bit9_reached", ok, 1);
    rst = 1'b1;
    base_d = done_cnt;
    cyc(1);
    chk("mid_rst_outs", outs(), RST_OUTS);
    rst = 1'b0;
    cyc(20);
    chk("mid_no_done", done_cnt - base_d, 0);
    chk("mid_idle_ready", {sif.in_ready, spi_ss, spi_sck}, 3'b110);

    // Fresh frame after the abandoned one, with a patterned miso responder.
    slv_din        = 16'h5AC3;
    sif.in_sample  = 10'h0C3;
    sif.in_channel = 4'h9;
    sif.in_valid   = 1'b1;
    base_r = rises;
    cyc(1);
    sif.in_valid = 1'b0;
    wait_done(ok);
    chk("f3_done_seen", ok, 1);
    chk("f3_bytes", mosi_sh[15:0], 16'hC390);
    chk("f3_ss_low", last_low, 66);
    chk("f3_rises", rises - base_r, 16);
    chk("f3_rx", rx_data, CAP ? 16'hC35A : 16'h0000);

    // in_valid raised during GAP is held off until IDLE.
    sif.in_sample  = 10'h17E;
    sif.in_channel = 4'h6;
    sif.in_valid   = 1'b1;
    cyc(3);
    chk("gap_not_ready", {sif.in_ready, spi_ss, busy}, 3'b011);
    cyc(1);
    chk("gap_idle_ready", {sif.in_ready, spi_ss, busy}, 3'b110);
    cyc(1);
    sif.in_valid = 1'b0;
    chk("gap_accepted", {sif.in_ready, spi_ss, busy}, 3'b001);
    base_r = rises;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      cyc(1);
      if (rises - base_r == 3) ok = 1'b1;
    end
    chk("f4_bit3_reached", ok, 1);
    sif.in_sample  = 10'h000;
    sif.in_channel = 4'h0;
    wait_done(ok);
    chk("f4_done_seen", ok, 1);
    chk("f4_bytes", mosi_sh[15:0], 16'h7E61);
    chk("f4_ss_high", last_high, 5);
    chk("f4_rx", rx_data, CAP ? 16'hC35A : 16'h0000);
    cyc(6);
    chk("final_idle", {sif.in_ready, busy, spi_ss, spi_sck, spi_mosi}, 5'b10100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
